mc14500x_icu: RTL

- Parametrised successor to the 1-bit MC14500 industrial control unit in the multi-project mux.
- Fetches instructions from an external asynchronous ROM and executes one instruction per clock.
- I/O width, input/output latch count and PC width are parameters.
- Adds absolute two-word jumps, subroutine CALL/RTN with a hardware return stack, and bit-banged serial through dedicated I/O addresses (SCLK/SDO/SDI).

---
 rtl/mc14500x_pkg.sv | 33 +++
 rtl/mc14500x_stack.sv | 56 +++++
 rtl/mc14500x_icu.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mc14500x_pkg.sv
// Shared opcode/state types and reserved I/O address helpers for the MC14500X ICU.
package mc14500x_pkg;

    typedef enum logic [3:0] {
        OpNopo = 4'h0, OpLd   = 4'h1, OpLdc  = 4'h2, OpAnd  = 4'h3,
        OpAndc = 4'h4, OpOr   = 4'h5, OpOrc  = 4'h6, OpXnor = 4'h7,
        OpSto  = 4'h8, OpStoc = 4'h9, OpIen  = 4'hA, OpOen  = 4'hB,
        OpJmp  = 4'hC, OpRtn  = 4'hD, OpSkz  = 4'hE, OpCall = 4'hF
    } opcode_e;

    typedef enum logic [0:0] {
        StExec    = 1'b0,
        StOperand = 1'b1
    } state_e;

    // The top two addresses are reserved: reads see rr/sdi, writes hit sdo/sclk.
    function automatic int unsigned rr_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    function automatic int unsigned sdo_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

    function automatic int unsigned sdi_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    function automatic int unsigned sclk_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mc14500x_stack.sv
// Return-address stack: overflow overwrites the top entry, underflow is ignored; both set a
// sticky error flag.
module mc14500x_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_err
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]  r_sp;
    logic             r_err;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;

    assign w_full  = (r_sp == SP_W'(DEPTH));
    assign o_empty = (r_sp == '0);
    assign o_err   = r_err;

    always_comb begin
        o_top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) o_top = r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (i_push) begin
            if (w_full) r_err <= 1'b1;
            else        r_sp  <= r_sp + SP_W'(1);
        end else if (i_pop) begin
            if (o_empty) r_err <= 1'b1;
            else         r_sp  <= r_sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_full ? (i == DEPTH - 1) : (r_sp == SP_W'(i))) r_mem[i] <= i_data;
            end
        end
    end

endmodule

// File: rtl/mc14500x_icu.sv
// Parametrised 1-bit industrial control unit with two-word jumps and bit-banged serial I/O.
// Define MC14500X_STACK_EN to enable CALL/RTN with a hardware return stack.
module mc14500x_icu
    import mc14500x_pkg::*;
#(
    parameter int unsigned PC_W        = 12,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NUM_IN      = 8,
    parameter int unsigned NUM_OUT     = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_W-1:0]     pc_o,
    input  logic [ADDR_W+3:0]   instr_i,
    input  logic [NUM_IN-1:0]   in_i,
    input  logic                sdi_i,
    output logic [NUM_OUT-1:0]  out_o,
    output logic                sdo_o,
    output logic                sclk_o,
    output logic                rr_o,
    output logic                flag_o,
    output logic                stack_err_o
);

    localparam logic [ADDR_W-1:0] L_RR_ADDR   = ADDR_W'(rr_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] L_SDI_ADDR  = ADDR_W'(sdi_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] L_SDO_ADDR  = ADDR_W'(sdo_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] L_SCLK_ADDR = ADDR_W'(sclk_addr(ADDR_W));

    state_e               r_state, w_state_d;
    logic [PC_W-1:0]      r_pc, w_pc_d, w_pc_inc, w_target;
    logic                 r_rr, w_rr_d;
    logic                 r_ien, w_ien_d;
    logic                 r_oen, w_oen_d;
    logic                 r_skip, w_skip_d;
    logic                 r_flag, w_flag_d;
    logic [ADDR_W-1:0]    r_opd, w_opd_d;
    logic [NUM_OUT-1:0]   r_out, w_out_d;
    logic                 r_sdo, w_sdo_d;
    logic                 r_sclk, w_sclk_d;

    opcode_e              w_op;
    logic [ADDR_W-1:0]    w_a;
    logic                 w_rd, w_d;
    logic                 w_wr_en, w_wr_val;

`ifdef MC14500X_STACK_EN
    logic                 r_call, w_call_d;
    logic                 w_push, w_pop;
    logic [PC_W-1:0]      w_stk_top;
    logic                 w_stk_empty, w_stk_err;
`else
    logic                 w_unused_depth;
`endif

    assign w_op     = opcode_e'(instr_i[ADDR_W+3:ADDR_W]);
    assign w_a      = instr_i[ADDR_W-1:0];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = PC_W'({r_opd, instr_i});

    always_comb begin
        w_rd = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (w_a == ADDR_W'(i)) w_rd = in_i[i];
        end
        if (w_a == L_SDI_ADDR)     w_rd = sdi_i;
        else if (w_a == L_RR_ADDR) w_rd = r_rr;
    end

    assign w_d = w_rd & r_ien;

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = w_pc_inc;
        w_rr_d    = r_rr;
        w_ien_d   = r_ien;
        w_oen_d   = r_oen;
        w_skip_d  = 1'b0;
        w_flag_d  = 1'b0;
        w_opd_d   = r_opd;
        w_wr_en   = 1'b0;
        w_wr_val  = r_rr;
        w_out_d   = r_out;
        w_sdo_d   = r_sdo;
        w_sclk_d  = r_sclk;
`ifdef MC14500X_STACK_EN
        w_call_d  = r_call;
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        unique case (r_state)
            StExec: begin
                if (r_skip) begin
                    // A skipped two-word op also steps over its operand word.
                    if (w_op == OpJmp || w_op == OpCall) w_pc_d = r_pc + PC_W'(2);
                end else begin
                    case (w_op)
                        OpNopo: w_flag_d = 1'b1;
                        OpLd:   w_rr_d   = w_d;
                        OpLdc:  w_rr_d   = ~w_d;
                        OpAnd:  w_rr_d   = r_rr & w_d;
                        OpAndc: w_rr_d   = r_rr & ~w_d;
                        OpOr:   w_rr_d   = r_rr | w_d;
                        OpOrc:  w_rr_d   = r_rr | ~w_d;
                        OpXnor: w_rr_d   = ~(r_rr ^ w_d);
                        OpSto:  w_wr_en  = r_oen;
                        OpStoc: begin
                            w_wr_en  = r_oen;
                            w_wr_val = ~r_rr;
                        end
                        OpIen:  w_ien_d  = w_rd;
                        OpOen:  w_oen_d  = w_rd;
                        OpJmp, OpCall: begin
                            w_opd_d   = w_a;
                            w_state_d = StOperand;
`ifdef MC14500X_STACK_EN
                            w_call_d  = (w_op == OpCall);
`endif
                        end
                        OpRtn: begin
                            w_skip_d = 1'b1;
`ifdef MC14500X_STACK_EN
                            w_pop = 1'b1;
                            if (!w_stk_empty) w_pc_d = w_stk_top;
`endif
                        end
                        OpSkz:  w_skip_d = ~r_rr;
                    endcase
                end
            end
            StOperand: begin
                w_pc_d    = w_target;
                w_state_d = StExec;
`ifdef MC14500X_STACK_EN
                w_push    = r_call;
`endif
            end
            default: ;
        endcase

        if (w_wr_en) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                if (w_a == ADDR_W'(i)) w_out_d[i] = w_wr_val;
            end
            if (w_a == L_SDO_ADDR)  w_sdo_d  = w_wr_val;
            if (w_a == L_SCLK_ADDR) w_sclk_d = w_wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StExec;
            r_pc    <= '0;
            r_rr    <= 1'b0;
            r_ien   <= 1'b1;
            r_oen   <= 1'b1;
            r_skip  <= 1'b0;
            r_flag  <= 1'b0;
            r_opd   <= '0;
            r_out   <= '0;
            r_sdo   <= 1'b0;
            r_sclk  <= 1'b0;
`ifdef MC14500X_STACK_EN
            r_call  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_rr    <= w_rr_d;
            r_ien   <= w_ien_d;
            r_oen   <= w_oen_d;
            r_skip  <= w_skip_d;
            r_flag  <= w_flag_d;
            r_opd   <= w_opd_d;
            r_out   <= w_out_d;
            r_sdo   <= w_sdo_d;
            r_sclk  <= w_sclk_d;
`ifdef MC14500X_STACK_EN
            r_call  <= w_call_d;
`endif
        end
    end

`ifdef MC14500X_STACK_EN
    mc14500x_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_empty (w_stk_empty),
        .o_err   (w_stk_err)
    );
    assign stack_err_o = w_stk_err;
`else
    assign w_unused_depth = ^STACK_DEPTH;
    assign stack_err_o    = 1'b0;
`endif

    assign pc_o   = r_pc;
    assign out_o  = r_out;
    assign sdo_o  = r_sdo;
    assign sclk_o = r_sclk;
    assign rr_o   = r_rr;
    assign flag_o = r_flag;

endmodule
